// File: rtl/fifo_ptr_ctrl.sv
// FIFO pointer controller: synchronises asynchronous write/read requests,
// drives RAM enables/addresses, tracks occupancy, status and sticky errors.
module fifo_ptr_ctrl #(
  parameter int unsigned ADDR_W    = 6,
  parameter int unsigned AF_LEVEL  = (1 << ADDR_W) - 4,
  parameter int unsigned AE_LEVEL  = 4,
  parameter int unsigned STEP_MODE = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_req,
  input  logic              rd_req,
  input  logic              flush,
  input  logic              clr_err,
  output logic              we,
  output logic              re,
  output logic [ADDR_W-1:0] waddr,
  output logic [ADDR_W-1:0] raddr,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_LEVEL);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_RDWR  = 2'd3
  } state_e;

  logic              wr_s1_q, wr_s2_q, wr_s3_q;
  logic              rd_s1_q, rd_s2_q, rd_s3_q;
  logic              wr_s1_d, wr_s2_d, wr_s3_d;
  logic              rd_s1_d, rd_s2_d, rd_s3_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  state_e            state_q, state_d;

  logic              wr_op, rd_op, rd_acc;

  // Status flags decoded from the registered occupancy only
  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);

  assign count     = count_q;
  assign waddr     = wptr_q;
  assign raddr     = rptr_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  // Operation strobes and RAM enables; flush suppresses both enables
  always_comb begin
    wr_op  = 1'b0;
    rd_op  = 1'b0;
    rd_acc = 1'b0;
    we     = 1'b0;
    re     = 1'b0;
    if (STEP_MODE != 0) begin
      wr_op = wr_s2_q & ~wr_s3_q;
      rd_op = rd_s2_q & ~rd_s3_q;
    end else begin
      wr_op = wr_s2_q;
      rd_op = rd_s2_q;
    end
    rd_acc = rd_op & ~empty & ~flush;
    re     = rd_acc;
    we     = wr_op & (~full | rd_acc) & ~flush;
  end

  // Next-state for synchronisers, pointers, occupancy and sticky errors
  always_comb begin
    wr_s1_d     = wr_req;
    wr_s2_d     = wr_s1_q;
    wr_s3_d     = wr_s2_q;
    rd_s1_d     = rd_req;
    rd_s2_d     = rd_s1_q;
    rd_s3_d     = rd_s2_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q & ~clr_err;
    underflow_d = underflow_q & ~clr_err;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (we) wptr_d = wptr_q + ADDR_W'(1);
      if (re) rptr_d = rptr_q + ADDR_W'(1);
      if (we && !re) begin
        count_d = count_q + CNT_W'(1);
      end else if (re && !we) begin
        count_d = count_q - CNT_W'(1);
      end
      // A new error wins over a clear in the same cycle
      if (wr_op && !we) overflow_d = 1'b1;
      if (rd_op && !re) underflow_d = 1'b1;
    end
  end

  // Debug FSM: records which operations were accepted last cycle
  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE, ST_WRITE, ST_READ, ST_RDWR: begin
        if (we && re) begin
          state_d = ST_RDWR;
        end else if (we) begin
          state_d = ST_WRITE;
        end else if (re) begin
          state_d = ST_READ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with asynchronous reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_s1_q     <= 1'b0;
      wr_s2_q     <= 1'b0;
      wr_s3_q     <= 1'b0;
      rd_s1_q     <= 1'b0;
      rd_s2_q     <= 1'b0;
      rd_s3_q     <= 1'b0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      state_q     <= ST_IDLE;
    end else begin
      wr_s1_q     <= wr_s1_d;
      wr_s2_q     <= wr_s2_d;
      wr_s3_q     <= wr_s3_d;
      rd_s1_q     <= rd_s1_d;
      rd_s2_q     <= rd_s2_d;
      rd_s3_q     <= rd_s3_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      state_q     <= state_d;
    end
  end

endmodule
